// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler produces a periodic step tick and a pattern engine
// advances binary, Gray, rotating-dot or bouncing-dot patterns one step per tick.
module led_pattern_gen #(
    parameter int N_LEDS     = 6,
    parameter int WAIT_TIME  = 13500000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [1:0]        mode,
    output logic              tick,
    output logic [N_LEDS-1:0] led
);

    localparam int PRE_W = $clog2(WAIT_TIME + 1);
    localparam int POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(WAIT_TIME - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE = PRE_W'(1);
    localparam logic [POS_W-1:0]  POS_MAX = POS_W'(N_LEDS - 1);
    localparam logic [POS_W-1:0]  POS_ONE = POS_W'(1);
    localparam logic [N_LEDS-1:0] CNT_ONE = N_LEDS'(1);
    localparam logic [N_LEDS-1:0] LED_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [PRE_W-1:0]  pre, pre_n;
    logic [N_LEDS-1:0] cnt, cnt_n;
    logic [POS_W-1:0]  pos, pos_n;
    logic              bdir, bdir_n;
    logic [1:0]        mode_q;
    logic              mode_chg;
    logic              step;

    function automatic logic [N_LEDS-1:0] pattern(input logic [1:0]        m,
                                                  input logic [N_LEDS-1:0] c,
                                                  input logic [POS_W-1:0]  p);
        case (m)
            2'd0:    pattern = c;
            2'd1:    pattern = c ^ (c >> 1);
            default: pattern = CNT_ONE << p;
        endcase
    endfunction

    function automatic logic [N_LEDS-1:0] polarity(input logic [N_LEDS-1:0] pat);
        polarity = (ACTIVE_LOW != 0) ? ~pat : pat;
    endfunction

    assign mode_chg = (mode != mode_q);
    // A mode change pre-empts the step so the new pattern always starts from its origin.
    assign step     = en && (pre == PRE_MAX) && !mode_chg;

    always_comb begin
        pre_n  = pre;
        cnt_n  = cnt;
        pos_n  = pos;
        bdir_n = bdir;
        if (mode_chg) begin
            pre_n  = '0;
            cnt_n  = '0;
            pos_n  = (dir && mode == 2'd2) ? POS_MAX : '0;
            bdir_n = 1'b0;
        end else if (en) begin
            pre_n = (pre == PRE_MAX) ? '0 : pre + PRE_ONE;
            if (step) begin
                case (mode)
                    2'd0, 2'd1: cnt_n = dir ? cnt - CNT_ONE : cnt + CNT_ONE;
                    2'd2: begin
                        if (dir) pos_n = (pos == '0) ? POS_MAX : pos - POS_ONE;
                        else     pos_n = (pos == POS_MAX) ? '0 : pos + POS_ONE;
                    end
                    default: begin
                        // Ends reverse immediately, so neither end is shown twice in a row.
                        if (N_LEDS > 1) begin
                            if (pos == POS_MAX) begin
                                pos_n  = pos - POS_ONE;
                                bdir_n = 1'b1;
                            end else if (pos == '0) begin
                                pos_n  = pos + POS_ONE;
                                bdir_n = 1'b0;
                            end else begin
                                pos_n = bdir ? pos - POS_ONE : pos + POS_ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            cnt    <= '0;
            pos    <= '0;
            bdir   <= 1'b0;
            mode_q <= 2'd0;
            tick   <= 1'b0;
            led    <= LED_OFF;
        end else begin
            pre    <= pre_n;
            cnt    <= cnt_n;
            pos    <= pos_n;
            bdir   <= bdir_n;
            mode_q <= mode;
            tick   <= step;
            // Built from next-state values so led changes land on the same edge as tick.
            led    <= polarity(pattern(mode, cnt_n, pos_n));
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-LED / 4-cycle instance and a 1-LED active-low
// instance stepping every cycle.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, en, dir;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] led;

    logic       rst1, en1, dir1;
    logic [1:0] mode1;
    logic       tick1;
    logic [0:0] led1;

    int total = 0;
    int bad   = 0;

    led_pattern_gen #(.N_LEDS(4), .WAIT_TIME(4), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .tick(tick), .led(led)
    );

    led_pattern_gen #(.N_LEDS(1), .WAIT_TIME(1), .ACTIVE_LOW(1)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .dir(dir1), .mode(mode1), .tick(tick1), .led(led1)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advances until tick is seen; n is the number of edges taken (50 means timed out).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < 50);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; dir = 1'b0; mode = 2'd0;
        rst1 = 1'b1; en1 = 1'b1; dir1 = 1'b0; mode1 = 2'd0;
        repeat (2) cyc();
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b exp=0000", led); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (led1 !== 1'b1) begin bad++; $display("FAIL reset_led_al got=%b exp=1", led1); end
        rst = 1'b0;
    endtask

    task automatic test_binary();
        int n;
        logic [3:0] exp_led;
        for (int k = 1; k <= 17; k++) begin
            wait_tick(n);
            exp_led = 4'(k % 16);
            total++; if (n !== 4) begin bad++; $display("FAIL bin_spacing step=%0d got=%0d exp=4", k, n); end
            total++; if (led !== exp_led) begin bad++; $display("FAIL bin_led step=%0d got=%b exp=%b", k, led, exp_led); end
        end
    endtask

    task automatic test_gray_down();
        int n;
        logic [3:0] exp_seq [4] = '{4'b1000, 4'b1001, 4'b1011, 4'b1010};
        mode = 2'd1; dir = 1'b1;
        cyc();
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL gray_switch_led got=%b exp=0000", led); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL gray_switch_tick got=%b exp=0", tick); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            total++; if (n !== 4) begin bad++; $display("FAIL gray_spacing step=%0d got=%0d exp=4", k, n); end
            total++; if (led !== exp_seq[k]) begin bad++; $display("FAIL gray_led step=%0d got=%b exp=%b", k, led, exp_seq[k]); end
        end
    endtask

    task automatic test_bounce();
        int n;
        logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        mode = 2'd3;
        cyc();
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL bounce_switch_led got=%b exp=0001", led); end
        for (int k = 0; k < 7; k++) begin
            wait_tick(n);
            total++; if (led !== exp_seq[k]) begin bad++; $display("FAIL bounce_led step=%0d got=%b exp=%b", k, led, exp_seq[k]); end
        end
    endtask

    task automatic test_rotate_pause();
        int n;
        logic [3:0] up_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        mode = 2'd2; dir = 1'b0;
        cyc();
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL rot_switch_led got=%b exp=0001", led); end
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            total++; if (led !== up_seq[k]) begin bad++; $display("FAIL rot_up_led step=%0d got=%b exp=%b", k, led, up_seq[k]); end
        end
        dir = 1'b1;
        wait_tick(n);
        total++; if (led !== 4'b1000) begin bad++; $display("FAIL rot_down_wrap got=%b exp=1000", led); end
        wait_tick(n);
        total++; if (led !== 4'b0100) begin bad++; $display("FAIL rot_down_led got=%b exp=0100", led); end
        repeat (2) cyc();
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL pause_tick cyc=%0d got=%b exp=0", k, tick); end
            total++; if (led !== 4'b0100) begin bad++; $display("FAIL pause_led cyc=%0d got=%b exp=0100", k, led); end
        end
        en = 1'b1;
        wait_tick(n);
        total++; if (n !== 2) begin bad++; $display("FAIL resume_spacing got=%0d exp=2", n); end
        total++; if (led !== 4'b0010) begin bad++; $display("FAIL resume_led got=%b exp=0010", led); end
        mode = 2'd0;
        cyc();
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL mode0_switch_led got=%b exp=0000", led); end
        mode = 2'd2;
        cyc();
        total++; if (led !== 4'b1000) begin bad++; $display("FAIL rot_down_start got=%b exp=1000", led); end
        wait_tick(n);
        total++; if (n !== 4) begin bad++; $display("FAIL rot_restart_spacing got=%0d exp=4", n); end
        total++; if (led !== 4'b0100) begin bad++; $display("FAIL rot_restart_led got=%b exp=0100", led); end
    endtask

    task automatic test_async_reset();
        int n;
        mode = 2'd3;
        cyc();
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL rst6_switch_led got=%b exp=0001", led); end
        wait_tick(n);
        wait_tick(n);
        total++; if (led !== 4'b0100) begin bad++; $display("FAIL rst6_pre_led got=%b exp=0100", led); end
        #2 rst = 1'b1;
        #1;
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst6_async_tick got=%b exp=0", tick); end
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL rst6_async_led got=%b exp=0000", led); end
        cyc();
        total++; if (led !== 4'b0000 || tick !== 1'b0) begin bad++; $display("FAIL rst6_hold got=%b/%b exp=0000/0", led, tick); end
        rst = 1'b0;
        cyc();
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL rst6_reload_led got=%b exp=0001", led); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL rst6_reload_tick got=%b exp=0", tick); end
        wait_tick(n);
        total++; if (n !== 4) begin bad++; $display("FAIL rst6_spacing got=%0d exp=4", n); end
        total++; if (led !== 4'b0010) begin bad++; $display("FAIL rst6_led got=%b exp=0010", led); end
    endtask

    task automatic test_single_led();
        logic exp_led;
        rst1 = 1'b0;
        exp_led = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            exp_led = ~exp_led;
            total++; if (tick1 !== 1'b1) begin bad++; $display("FAIL al_tick cyc=%0d got=%b exp=1", k, tick1); end
            total++; if (led1 !== exp_led) begin bad++; $display("FAIL al_led cyc=%0d got=%b exp=%b", k, led1, exp_led); end
        end
        mode1 = 2'd3;
        cyc();
        total++; if (tick1 !== 1'b0) begin bad++; $display("FAIL al_switch_tick got=%b exp=0", tick1); end
        total++; if (led1 !== 1'b0) begin bad++; $display("FAIL al_switch_led got=%b exp=0", led1); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (tick1 !== 1'b1) begin bad++; $display("FAIL al_bounce_tick cyc=%0d got=%b exp=1", k, tick1); end
            total++; if (led1 !== 1'b0) begin bad++; $display("FAIL al_bounce_led cyc=%0d got=%b exp=0", k, led1); end
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_gray_down();
        test_bounce();
        test_rotate_pause();
        test_async_reset();
        test_single_led();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
